// File: rtl/trdb_pkg.sv
// Shared trace-encoder types: packet formats, serializer states and the
// header-byte layout used by the packet serializer.
package trdb_pkg;

  localparam int TRDB_MAX_PAYLOAD_BYTES = 16;
  localparam int TRDB_LEN_W             = $clog2(TRDB_MAX_PAYLOAD_BYTES + 1);

  // Header byte: format in the top two bits, payload length below it.
  localparam int TRDB_HDR_FMT_LSB = 6;
  localparam int TRDB_HDR_FMT_W   = 2;
  localparam int TRDB_HDR_LEN_LSB = 0;
  localparam int TRDB_HDR_LEN_W   = 6;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef struct packed {
    trdb_format_e                            format;
    logic [1:0]                              subformat;
    logic [TRDB_LEN_W-1:0]                   len;
    logic [8*TRDB_MAX_PAYLOAD_BYTES-1:0]     payload;
  } trdb_packet_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } trdb_ser_state_e;

  function automatic logic [7:0] trdb_header_byte(input trdb_format_e fmt,
                                                  input logic [TRDB_HDR_LEN_W-1:0] len);
    logic [7:0] hdr;
    hdr = '0;
    hdr[TRDB_HDR_FMT_LSB +: TRDB_HDR_FMT_W] = fmt;
    hdr[TRDB_HDR_LEN_LSB +: TRDB_HDR_LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/trdb_packet_serializer.sv
// Serializes one assembled trace packet into a header byte plus LSB-first
// payload bytes on a valid/ready byte stream; drops packets with bad length.
module trdb_packet_serializer
  import trdb_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 16,
  parameter int LEN_W         = $clog2(PAYLOAD_BYTES + 1),
  parameter int CNT_W         = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       packet_valid_i,
  output logic                       packet_ready_o,
  input  logic [1:0]                 packet_format_i,
  input  logic [1:0]                 packet_subformat_i,
  input  logic [8*PAYLOAD_BYTES-1:0] packet_payload_i,
  input  logic [LEN_W-1:0]           packet_len_i,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic [7:0]                 byte_data_o,
  output logic                       byte_last_o,
  output logic                       err_len_o,
  input  logic                       err_clr_i,
  output logic [CNT_W-1:0]           pkt_cnt_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAYLOAD_BYTES);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  trdb_ser_state_e             state_q;
  trdb_format_e                fmt_q;
  logic [LEN_W-1:0]            len_q;
  logic [8*PAYLOAD_BYTES-1:0]  buf_q;
  logic [LEN_W-1:0]            idx_q;
  logic [LEN_W-1:0]            idx_d;
  logic                        byte_valid_q;
  logic [7:0]                  byte_data_q;
  logic                        byte_last_q;
  logic                        err_q;
  logic [CNT_W-1:0]            cnt_q;

  logic                        accept;
  logic                        len_ok;
  logic                        load;
  logic                        drop;
  logic                        last_hs;
  logic [7:0]                  next_byte_d;
  logic [7:0]                  hdr_d;

  // The final-byte handshake frees the buffer in the same cycle, so a new
  // packet can be taken without a bubble.
  assign last_hs        = (state_q == BODY) && byte_last_q && byte_ready_i;
  assign packet_ready_o = (state_q == IDLE) || last_hs;
  assign accept         = packet_valid_i && packet_ready_o;
  // Every subformat encoding is legal; only the length can disqualify a packet.
  assign len_ok         = (packet_len_i != '0) && (packet_len_i <= MAX_LEN) &&
                          (packet_subformat_i inside {2'd0, 2'd1, 2'd2, 2'd3});
  assign load           = accept && len_ok;
  assign drop           = accept && !len_ok;
  assign hdr_d          = trdb_header_byte(trdb_format_e'(packet_format_i),
                                           TRDB_HDR_LEN_W'(packet_len_i));

  always_comb begin
    idx_d       = idx_q + 1'b1;
    next_byte_d = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (idx_d == LEN_W'(i)) next_byte_d = buf_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fmt_q        <= F_OPT_EXT;
      len_q        <= '0;
      buf_q        <= '0;
      idx_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_last_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (drop)           err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;

      if (last_hs) cnt_q <= cnt_q + 1'b1;

      if (load) begin
        state_q      <= HEADER;
        fmt_q        <= trdb_format_e'(packet_format_i);
        len_q        <= packet_len_i;
        buf_q        <= packet_payload_i;
        idx_q        <= '0;
        byte_valid_q <= 1'b1;
        byte_data_q  <= hdr_d;
        byte_last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            byte_valid_q <= 1'b0;
          end
          HEADER: begin
            if (byte_ready_i) begin
              state_q     <= BODY;
              byte_data_q <= buf_q[7:0];
              byte_last_q <= (len_q == ONE_LEN);
            end
          end
          BODY: begin
            if (byte_ready_i) begin
              if (byte_last_q) begin
                state_q      <= IDLE;
                byte_valid_q <= 1'b0;
                byte_data_q  <= '0;
                byte_last_q  <= 1'b0;
              end else begin
                idx_q       <= idx_d;
                byte_data_q <= next_byte_d;
                byte_last_q <= (idx_d == len_q - ONE_LEN);
              end
            end
          end
          default: begin
            state_q      <= IDLE;
            byte_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_last_o  = byte_last_q;
  assign err_len_o    = err_q;
  assign pkt_cnt_o    = cnt_q;

endmodule
